// File: rtl/div_result_buf.sv
// div_result_buf
// Result buffer and credit manager for the pipelined restoring divider.
// Each quotient/remainder pair that the divider strobes out on res_rdy is
// captured into a first-word-fall-through FIFO. The pair is then presented
// on a valid/ready interface. The divider pipeline cannot stall, so a credit
// counter tracks in-flight divides plus stored results. The issuer may launch
// a divide only while credit_avail is high, so no result is ever lost.
//
// Optional feature macro: DIVBUF_ERR_EN
//   When defined, a sticky err output flags two protocol violations:
//   an issue without credit, and a push dropped because the FIFO was full.
//   err clears only on rst.
//
// DEPTH must be a power of two and at least 2.

module div_result_buf #(
  parameter int N     = 21,
  parameter int M     = 13,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue,
  input  logic                       res_rdy,
  input  logic [N-1:0]               merchant,
  input  logic [M-1:0]               remainder,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_quot,
  output logic [M-1:0]               out_rem,
  output logic                       credit_avail,
  output logic [$clog2(DEPTH):0]     level
`ifdef DIVBUF_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Width-matched constants keep the arithmetic below free of implicit
  // extension.
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_V  = '0;

  typedef struct packed {
    logic [N-1:0] quot;
    logic [M-1:0] rem;
  } entry_t;

  entry_t      mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic [AW:0] cnt;

  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        take_issue;
  logic        cnt_dec;
  entry_t      head;

  // FIFO status and handshake qualification.
  // NOTE: every signal assigned in an always_comb is given a value on every
  // path; here each one is assigned unconditionally, so no latch can form.
  always_comb begin
    empty      = (wp == rp);
    full       = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    pop        = !empty && out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    push       = res_rdy && (!full || pop);
    take_issue = issue && credit_avail;
    // Results that arrive after a reset were never counted. Popping them must
    // not wrap the credit count below zero.
    cnt_dec    = pop && (cnt != ZERO_V);
  end

  // First-word-fall-through head: the entry at rp is always on the outputs.
  assign head         = mem[rp[AW-1:0]];
  assign out_quot     = head.quot;
  assign out_rem      = head.rem;
  assign out_valid    = !empty;
  assign level        = wp - rp;
  assign credit_avail = (cnt < DEPTH_V);

  // Storage array write.
  // NOTE: the RAM has no reset. The pointers alone define which entries are
  // valid, and a reset-free array maps onto plain memory cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= '{quot: merchant, rem: remainder};
    end
  end

  // Write and read pointers with a wrap bit in the MSB.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= ZERO_V;
      rp <= ZERO_V;
    end else begin
      if (push) wp <= wp + ONE_V;
      if (pop)  rp <= rp + ONE_V;
    end
  end

  // Credit count covering in-flight divides plus stored entries.
  // A result arriving does not change it; the result only moves from
  // in-flight to stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= ZERO_V;
    end else begin
      unique case ({take_issue, cnt_dec})
        2'b10:   cnt <= cnt + ONE_V;
        2'b01:   cnt <= cnt - ONE_V;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef DIVBUF_ERR_EN
  logic issue_violation;
  logic drop_violation;

  // Protocol violations that feed the sticky error flag.
  always_comb begin
    issue_violation = issue && !credit_avail;
    drop_violation  = res_rdy && !push;
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (issue_violation || drop_violation) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_buf.sv
// tb_div_result_buf
// Directed-vector bench for div_result_buf (N=21, M=13, DEPTH=32).
// Inputs change just after the falling edge, and outputs are sampled on the
// falling edge, which is half a cycle after the rising edge that updates them.
// The err checks are included when DIVBUF_ERR_EN is defined.

module tb_div_result_buf;

  localparam int N     = 21;
  localparam int M     = 13;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue;
  logic          res_rdy;
  logic [N-1:0]  merchant;
  logic [M-1:0]  remainder;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_quot;
  logic [M-1:0]  out_rem;
  logic          credit_avail;
  logic [LW-1:0] level;
`ifdef DIVBUF_ERR_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  div_result_buf #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .res_rdy      (res_rdy),
    .merchant     (merchant),
    .remainder    (remainder),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .credit_avail (credit_avail),
    .level        (level)
`ifdef DIVBUF_ERR_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue     = 1'b0;
    res_rdy   = 1'b0;
    merchant  = '0;
    remainder = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", level); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL reset_credit got=%b want=1", credit_avail); end
`ifdef DIVBUF_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
`endif
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    do_reset();
    issue = 1'b1;
    cycle();
    issue = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_valid got=%b want=0", out_valid); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL single_pre_credit got=%b want=1", credit_avail); end
    repeat (20) cycle();
    res_rdy   = 1'b1;
    merchant  = 21'd14;
    remainder = 13'd2;
    cycle();
    res_rdy = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_quot !== 21'd14) begin n_bad++; $display("FAIL single_quot got=%0d want=14", out_quot); end
    n_cmp++; if (out_rem !== 13'd2) begin n_bad++; $display("FAIL single_rem got=%0d want=2", out_rem); end
    n_cmp++; if (level !== 6'd1) begin n_bad++; $display("FAIL single_level got=%0d want=1", level); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL single_pop_level got=%0d want=0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid got=%b want=0", out_valid); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL single_pop_credit got=%b want=1", credit_avail); end
  endtask

  task automatic test_credit();
    logic want;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue = 1'b1;
      cycle();
      want = (i < DEPTH - 1);
      n_cmp++; if (credit_avail !== want) begin n_bad++; $display("FAIL credit_issue%0d got=%b want=%b", i, credit_avail, want); end
    end
    // The 33rd issue is refused and is not counted.
    cycle();
    issue = 1'b0;
    n_cmp++; if (credit_avail !== 1'b0) begin n_bad++; $display("FAIL credit_33rd got=%b want=0", credit_avail); end
`ifdef DIVBUF_ERR_EN
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL credit_err got=%b want=1", err); end
`endif
    // A single pop must restore credit. That holds only if the refused issue
    // was not counted.
    res_rdy  = 1'b1;
    merchant = 21'd1;
    cycle();
    res_rdy   = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL credit_after_pop got=%b want=1", credit_avail); end
  endtask

  task automatic test_full_push_pop();
    logic [N-1:0] eq;
    logic [M-1:0] er;
    do_reset();
    issue = 1'b1;
    repeat (DEPTH) cycle();
    issue = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      res_rdy   = 1'b1;
      merchant  = N'(100 + i);
      remainder = M'(i);
      cycle();
    end
    res_rdy = 1'b0;
    n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL full_level got=%0d want=32", level); end
    n_cmp++; if (out_quot !== 21'd100) begin n_bad++; $display("FAIL full_head got=%0d want=100", out_quot); end
`ifdef DIVBUF_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err_clear got=%b want=0", err); end
`endif
    // Push and pop in the same cycle while full.
    res_rdy   = 1'b1;
    merchant  = 21'd5;
    remainder = 13'd0;
    out_ready = 1'b1;
    cycle();
    res_rdy   = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL pp_level got=%0d want=32", level); end
    n_cmp++; if (out_quot !== 21'd101 || out_rem !== 13'd1) begin n_bad++; $display("FAIL pp_head got=%0d/%0d want=101/1", out_quot, out_rem); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL pp_credit got=%b want=1", credit_avail); end
    issue = 1'b1;
    cycle();
    issue = 1'b0;
    n_cmp++; if (credit_avail !== 1'b0) begin n_bad++; $display("FAIL pp_reissue_credit got=%b want=0", credit_avail); end
    // A push into a full FIFO with no pop is dropped.
    res_rdy   = 1'b1;
    merchant  = 21'd9;
    remainder = 13'd1;
    cycle();
    res_rdy = 1'b0;
    n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL drop_level got=%0d want=32", level); end
    n_cmp++; if (out_quot !== 21'd101) begin n_bad++; $display("FAIL drop_head got=%0d want=101", out_quot); end
`ifdef DIVBUF_ERR_EN
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL drop_err got=%b want=1", err); end
`endif
    // Back-to-back drain: 101..131, then 5/0. The dropped 9/1 must not appear.
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      eq = (i < DEPTH - 1) ? N'(101 + i) : 21'd5;
      er = (i < DEPTH - 1) ? M'(1 + i)   : 13'd0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_quot !== eq || out_rem !== er) begin
        n_bad++;
        $display("FAIL drain%0d got=%b:%0d/%0d want=1:%0d/%0d", i, out_valid, out_quot, out_rem, eq, er);
      end
      cycle();
    end
    out_ready = 1'b0;
    n_cmp++; if (level !== 6'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got=%0d/%b want=0/0", level, out_valid); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL drain_credit got=%b want=1", credit_avail); end
  endtask

  task automatic test_streaming();
    int  seen;
    logic want_v;
    do_reset();
    seen = 0;
    out_ready = 1'b1;
    // Divider latency of 21 cycles: quotient q is strobed in cycle q+21.
    for (int c = 0; c < 124; c++) begin
      issue    = (c < 100);
      res_rdy  = (c >= 21 && c < 121);
      merchant = N'((c >= 21) ? c - 21 : 0);
      remainder = M'(c % 7);
      cycle();
      want_v = (c >= 21 && c < 121);
      n_cmp++;
      if (out_valid !== want_v) begin
        n_bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, out_valid, want_v);
      end else if (want_v) begin
        n_cmp++;
        if (out_quot !== N'(c - 21)) begin n_bad++; $display("FAIL stream_quot c=%0d got=%0d want=%0d", c, out_quot, c - 21); end
        else seen++;
      end
      n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL stream_credit c=%0d got=%b want=1", c, credit_avail); end
    end
    idle_inputs();
    n_cmp++; if (seen !== 100) begin n_bad++; $display("FAIL stream_count got=%0d want=100", seen); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    issue = 1'b1;
    repeat (20) cycle();
    issue = 1'b0;
    for (int i = 0; i < 10; i++) begin
      res_rdy  = 1'b1;
      merchant = N'(200 + i);
      cycle();
    end
    res_rdy = 1'b0;
    n_cmp++; if (level !== 6'd10) begin n_bad++; $display("FAIL mid_level_pre got=%0d want=10", level); end
    // Assert reset between clock edges; its effect must be immediate.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL mid_level got=%0d want=0", level); end
    n_cmp++; if (credit_avail !== 1'b1) begin n_bad++; $display("FAIL mid_credit got=%b want=1", credit_avail); end
`ifdef DIVBUF_ERR_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err got=%b want=0", err); end
`endif
    cycle();
    rst = 1'b0;
    // A result still in the divider pipeline after reset is pushed normally.
    res_rdy   = 1'b1;
    merchant  = 21'd77;
    remainder = 13'd3;
    cycle();
    res_rdy = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_quot !== 21'd77 || out_rem !== 13'd3) begin n_bad++; $display("FAIL mid_late_push got=%b:%0d/%0d want=1:77/3", out_valid, out_quot, out_rem); end
    n_cmp++; if (level !== 6'd1) begin n_bad++; $display("FAIL mid_late_level got=%0d want=1", level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_full_push_pop();
    test_streaming();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
